// File: rtl/channel_readout_pkg.sv
// Shared types and constants for the channel readout arbiter.
// Holds the FSM encoding, the frame format and the beat formatter.
package channel_readout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_SEND,
        ST_CLEAR
    } state_e;

    localparam int         DATA_W_DEF     = 120;
    localparam int         OUT_W_DEF      = 32;
    localparam int         BEATS          = 4;
    localparam int         CLR_CYCLES_DEF = 16;
    localparam logic [3:0] HEADER_DEF     = 4'hC;

    // Beat b of a frame built from word d captured from channel g.
    function automatic logic [31:0] beat_word(
        input logic [119:0] d,
        input logic [3:0]   hdr,
        input logic [1:0]   g,
        input logic [1:0]   b
    );
        logic [31:0] w;
        w = '0;
        unique case (b)
            2'd0: w = {hdr, 2'b00, g, d[119:96]};
            2'd1: w = d[95:64];
            2'd2: w = d[63:32];
            2'd3: w = d[31:0];
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational rotate-priority grant over four requesters.
// The first eligible index at or after ptr (mod 4) wins.
module rr_arbiter_4 (
    input  logic [3:0] eligible,
    input  logic [1:0] ptr,
    output logic       gnt_valid,
    output logic [1:0] gnt_idx
);

    logic [1:0] idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = ptr;
        idx       = '0;
        // Walk from farthest to nearest so the nearest hit wins.
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (eligible[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/channel_readout_arbiter.sv
// Round-robin reader of four 120-bit channel FIFOs, framing each word
// as four 32-bit beats; also sequences software FIFO clears.
module channel_readout_arbiter
    import channel_readout_pkg::*;
#(
    parameter int         DATA_W     = DATA_W_DEF,
    parameter int         OUT_W      = OUT_W_DEF,
    parameter int         CLR_CYCLES = CLR_CYCLES_DEF,
    parameter logic [3:0] HEADER     = HEADER_DEF
) (
    input  logic              clk160,
    input  logic              reset,
    input  logic              readout_en,
    input  logic [3:0]        ch_enable,
    input  logic              fifo_clear,
    input  logic              channel_fifo_empty_0,
    input  logic              channel_fifo_empty_1,
    input  logic              channel_fifo_empty_2,
    input  logic              channel_fifo_empty_3,
    input  logic [DATA_W-1:0] channel_data_0,
    input  logic [DATA_W-1:0] channel_data_1,
    input  logic [DATA_W-1:0] channel_data_2,
    input  logic [DATA_W-1:0] channel_data_3,
    output logic              channel_data_read_0,
    output logic              channel_data_read_1,
    output logic              channel_data_read_2,
    output logic              channel_data_read_3,
    output logic              channel_fifo_s_reset_0,
    output logic              channel_fifo_s_reset_1,
    output logic              channel_fifo_s_reset_2,
    output logic              channel_fifo_s_reset_3,
    output logic              data_tran_stop_0,
    output logic              data_tran_stop_1,
    output logic              data_tran_stop_2,
    output logic              data_tran_stop_3,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic [31:0]       frame_count,
    output logic              busy
);

    localparam int CW = $clog2(CLR_CYCLES + 2) + 1;

    logic [1:0] rst_sync_q;
    logic       rst_n;

    // Assert asynchronously, release two edges later on clk160.
    always_ff @(posedge clk160 or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    state_e            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        beat_q, beat_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [OUT_W-1:0]  odata_q, odata_d;
    logic              ovalid_q, ovalid_d;
    logic              olast_q, olast_d;
    logic [31:0]       fcnt_q, fcnt_d;
    logic              clr_pend_q, clr_pend_d;
    logic [CW-1:0]     clr_cnt_q, clr_cnt_d;

    logic [3:0]        empty;
    logic [3:0]        eligible;
    logic              gnt_valid;
    logic [1:0]        gnt_idx;
    logic [DATA_W-1:0] ch_data [4];
    logic [1:0]        beat_nx;

    assign empty = {channel_fifo_empty_3, channel_fifo_empty_2,
                    channel_fifo_empty_1, channel_fifo_empty_0};

    assign ch_data[0] = channel_data_0;
    assign ch_data[1] = channel_data_1;
    assign ch_data[2] = channel_data_2;
    assign ch_data[3] = channel_data_3;

    assign eligible = ~empty & ch_enable;
    assign beat_nx  = beat_q + 2'd1;

    rr_arbiter_4 u_rr (
        .eligible  (eligible),
        .ptr       (ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        beat_d     = beat_q;
        hold_d     = hold_q;
        odata_d    = odata_q;
        ovalid_d   = ovalid_q;
        olast_d    = olast_q;
        fcnt_d     = fcnt_q;
        clr_cnt_d  = clr_cnt_q;
        clr_pend_d = clr_pend_q | (fifo_clear & (state_q != ST_CLEAR));

        unique case (state_q)
            ST_IDLE: begin
                clr_cnt_d = '0;
                if (clr_pend_q || fifo_clear) begin
                    state_d = ST_CLEAR;
                end else if (readout_en && gnt_valid) begin
                    gnt_d   = gnt_idx;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                hold_d   = ch_data[gnt_q];
                odata_d  = beat_word(ch_data[gnt_q], HEADER, gnt_q, 2'd0);
                ovalid_d = 1'b1;
                olast_d  = 1'b0;
                beat_d   = 2'd0;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (ovalid_q && out_ready) begin
                    if (beat_q == 2'(BEATS - 1)) begin
                        odata_d  = '0;
                        ovalid_d = 1'b0;
                        olast_d  = 1'b0;
                        fcnt_d   = fcnt_q + 32'd1;
                        ptr_d    = gnt_q + 2'd1;
                        state_d  = ST_IDLE;
                    end else begin
                        beat_d  = beat_nx;
                        odata_d = beat_word(hold_q, HEADER, gnt_q, beat_nx);
                        olast_d = (beat_nx == 2'(BEATS - 1));
                    end
                end
            end
            ST_CLEAR: begin
                clr_pend_d = 1'b0;
                clr_cnt_d  = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CW'(CLR_CYCLES + 1)) begin
                    ptr_d   = 2'd0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk160 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            beat_q     <= '0;
            hold_q     <= '0;
            odata_q    <= '0;
            ovalid_q   <= 1'b0;
            olast_q    <= 1'b0;
            fcnt_q     <= '0;
            clr_pend_q <= 1'b0;
            clr_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            beat_q     <= beat_d;
            hold_q     <= hold_d;
            odata_q    <= odata_d;
            ovalid_q   <= ovalid_d;
            olast_q    <= olast_d;
            fcnt_q     <= fcnt_d;
            clr_pend_q <= clr_pend_d;
            clr_cnt_q  <= clr_cnt_d;
        end
    end

    logic rd_on;
    logic srst_on;
    logic stop_on;

    assign rd_on   = (state_q == ST_RD);
    assign stop_on = (state_q == ST_CLEAR);
    assign srst_on = stop_on && (clr_cnt_q < CW'(CLR_CYCLES));

    assign channel_data_read_0 = rd_on && (gnt_q == 2'd0);
    assign channel_data_read_1 = rd_on && (gnt_q == 2'd1);
    assign channel_data_read_2 = rd_on && (gnt_q == 2'd2);
    assign channel_data_read_3 = rd_on && (gnt_q == 2'd3);

    assign channel_fifo_s_reset_0 = srst_on;
    assign channel_fifo_s_reset_1 = srst_on;
    assign channel_fifo_s_reset_2 = srst_on;
    assign channel_fifo_s_reset_3 = srst_on;

    assign data_tran_stop_0 = stop_on;
    assign data_tran_stop_1 = stop_on;
    assign data_tran_stop_2 = stop_on;
    assign data_tran_stop_3 = stop_on;

    assign out_data    = odata_q;
    assign out_valid   = ovalid_q;
    assign out_last    = olast_q;
    assign frame_count = fcnt_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
